// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - format codes, field bit positions and FSM states shared by the
// instruction encoder and the CPU's field decoder.
package encoder_pkg;

   localparam logic [1:0] FMT_REG    = 2'd0;
   localparam logic [1:0] FMT_IMM    = 2'd1;
   localparam logic [1:0] FMT_BRANCH = 2'd2;
   localparam logic [1:0] FMT_JUMP   = 2'd3;

   // Bit positions inside the 32-bit word; the decoder slices from the same places.
   localparam int OPC_LSB  = 24;
   localparam int DST_LSB  = 16;
   localparam int SRC1_LSB = 8;
   localparam int SRC2_LSB = 0;
   localparam int REG_W    = 3;
   localparam int BYTE_W   = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR0  = 3'd1,
      ST_WR1  = 3'd2,
      ST_WR2  = 3'd3,
      ST_WR3  = 3'd4
   } state_e;

   function automatic state_e next_wr_state(input state_e s);
      case (s)
         ST_WR0:  return ST_WR1;
         ST_WR1:  return ST_WR2;
         ST_WR2:  return ST_WR3;
         default: return ST_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/instruction_packer.sv
// rtl/instruction_packer.sv - combinational packer from decoded fields plus FORMAT into one
// 32-bit instruction word; fields not used by the format stay zero.
module instruction_packer
   import encoder_pkg::*;
(
   input  logic [1:0]        format_i,
   input  logic [BYTE_W-1:0] opcode_i,
   input  logic [REG_W-1:0]  writereg_i,
   input  logic [REG_W-1:0]  readreg1_i,
   input  logic [REG_W-1:0]  readreg2_i,
   input  logic [BYTE_W-1:0] immediate_i,
   input  logic [BYTE_W-1:0] offset_i,
   output logic [31:0]       word_o
);

   always_comb begin
      word_o = '0;
      word_o[OPC_LSB +: BYTE_W] = opcode_i;
      case (format_i)
         FMT_REG: begin
            word_o[DST_LSB  +: REG_W] = writereg_i;
            word_o[SRC1_LSB +: REG_W] = readreg1_i;
            word_o[SRC2_LSB +: REG_W] = readreg2_i;
         end
         FMT_IMM: begin
            word_o[DST_LSB  +: REG_W]  = writereg_i;
            word_o[SRC2_LSB +: BYTE_W] = immediate_i;
         end
         FMT_BRANCH: begin
            word_o[DST_LSB  +: BYTE_W] = offset_i;
            word_o[SRC1_LSB +: REG_W]  = readreg1_i;
            word_o[SRC2_LSB +: REG_W]  = readreg2_i;
         end
         default: begin
            word_o[DST_LSB +: BYTE_W] = offset_i;
         end
      endcase
   end

endmodule

// File: rtl/instruction_encoder_loader.sv
// rtl/instruction_encoder_loader.sv - accepts instruction fields, packs them and writes each word
// byte-serially, little-endian, to instruction memory. Optional: ENCODER_OPCODE_CHECK_EN.
module instruction_encoder_loader
   import encoder_pkg::*;
#(
   parameter int         DEPTH      = 256,
   parameter logic [7:0] MAX_OPCODE = 8'h0F,
   localparam int        AW         = $clog2(DEPTH*4)
)(
   input  logic          CLK,
   input  logic          RESET,
   input  logic          CLEAR,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic [1:0]    FORMAT,
   input  logic [7:0]    OPCODE,
   input  logic [2:0]    WRITEREG,
   input  logic [2:0]    READREG1,
   input  logic [2:0]    READREG2,
   input  logic [7:0]    IMMEDIATE,
   input  logic [7:0]    OFFSET,
   output logic          MEM_WRITE,
   output logic [AW-1:0] MEM_ADDRESS,
   output logic [7:0]    MEM_WRITEDATA,
   input  logic          MEM_BUSYWAIT,
   output logic [AW-2:0] COUNT,
   output logic          FULL,
   output logic          ERR
);

   localparam int CW = AW - 1;

`ifdef ENCODER_OPCODE_CHECK_EN
   localparam bit OPCODE_CHECK = 1'b1;
`else
   localparam bit OPCODE_CHECK = 1'b0;
`endif

   state_e        state_q;
   logic [23:0]   upper_q;
   logic [CW-1:0] count_q;
   logic          mem_write_q;
   logic [AW-1:0] mem_addr_q;
   logic [7:0]    mem_data_q;
   logic          err_q;

   logic [31:0]   packed_word;
   logic          full;
   logic          handshake;
   logic          opcode_reject;
   logic [7:0]    next_byte;

   instruction_packer u_packer (
      .format_i    (FORMAT),
      .opcode_i    (OPCODE),
      .writereg_i  (WRITEREG),
      .readreg1_i  (READREG1),
      .readreg2_i  (READREG2),
      .immediate_i (IMMEDIATE),
      .offset_i    (OFFSET),
      .word_o      (packed_word)
   );

   assign full          = (count_q == CW'(DEPTH));
   assign IN_READY      = (state_q == ST_IDLE) && !full && !CLEAR;
   assign handshake     = IN_VALID && IN_READY;
   assign opcode_reject = OPCODE_CHECK && (OPCODE > MAX_OPCODE);

   // Byte 0 is loaded straight from the packer at the handshake, so only bytes 1..3 are kept.
   always_comb begin
      next_byte = upper_q[23:16];
      case (state_q)
         ST_WR0:  next_byte = upper_q[7:0];
         ST_WR1:  next_byte = upper_q[15:8];
         default: next_byte = upper_q[23:16];
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         upper_q     <= '0;
         count_q     <= '0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (CLEAR) begin
                  count_q <= '0;
               end else if (handshake) begin
                  if (opcode_reject) begin
                     err_q <= 1'b1;
                  end else begin
                     upper_q     <= packed_word[31:8];
                     state_q     <= ST_WR0;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= {count_q[AW-3:0], 2'b00};
                     mem_data_q  <= packed_word[7:0];
                  end
               end
            end
            ST_WR3: begin
               if (!MEM_BUSYWAIT) begin
                  state_q     <= ST_IDLE;
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_data_q  <= '0;
                  count_q     <= count_q + CW'(1);
               end
            end
            default: begin
               if (!MEM_BUSYWAIT) begin
                  state_q    <= next_wr_state(state_q);
                  mem_addr_q <= mem_addr_q + AW'(1);
                  mem_data_q <= next_byte;
               end
            end
         endcase
      end
   end

   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = mem_addr_q;
   assign MEM_WRITEDATA = mem_data_q;
   assign COUNT         = count_q;
   assign FULL          = full;
   assign ERR           = err_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// tb/tb_instruction_encoder_loader.sv - directed and randomized bench for instruction_encoder_loader
// with a queue-based model of the expected byte-write stream.
module tb_instruction_encoder_loader;

   localparam int         DEPTH = 4;
   localparam int         AW    = $clog2(DEPTH*4);
   localparam logic [7:0] MAXOP = 8'h0F;
`ifdef ENCODER_OPCODE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESET, CLEAR, IN_VALID, IN_READY;
   logic [1:0]    FORMAT;
   logic [7:0]    OPCODE, IMMEDIATE, OFFSET;
   logic [2:0]    WRITEREG, READREG1, READREG2;
   logic          MEM_WRITE, MEM_BUSYWAIT, FULL, ERR;
   logic [AW-1:0] MEM_ADDRESS;
   logic [7:0]    MEM_WRITEDATA;
   logic [AW-2:0] COUNT;

   always #5 CLK = ~CLK;

   instruction_encoder_loader #(.DEPTH(DEPTH), .MAX_OPCODE(MAXOP)) dut (
      .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .FORMAT(FORMAT), .OPCODE(OPCODE), .WRITEREG(WRITEREG), .READREG1(READREG1),
      .READREG2(READREG2), .IMMEDIATE(IMMEDIATE), .OFFSET(OFFSET), .MEM_WRITE(MEM_WRITE),
      .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
      .COUNT(COUNT), .FULL(FULL), .ERR(ERR)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack(input int unsigned fmt, op, wr, r1, r2, imm, off);
      case (fmt)
         0:       return (op << 24) + (wr << 16) + (r1 << 8) + r2;
         1:       return (op << 24) + (wr << 16) + imm;
         2:       return (op << 24) + (off << 16) + (r1 << 8) + r2;
         default: return (op << 24) + (off << 16);
      endcase
   endfunction

   // Model: pending byte writes as a queue; the head is what memory must see right now.
   int          q_addr[$];
   int          q_data[$];
   bit          q_last[$];
   int          m_count = 0;
   bit          m_err   = 1'b0;
   bit          hs_flag = 1'b0;
   bit          m_busy;
   logic [31:0] m_word;

   always @(posedge CLK or posedge RESET) begin
      hs_flag = 1'b0;
      if (RESET) begin
         q_addr.delete(); q_data.delete(); q_last.delete();
         m_count = 0;
         m_err   = 1'b0;
      end else begin
         m_err = 1'b0;
         if (q_addr.size() > 0) begin
            if (!MEM_BUSYWAIT) begin
               if (q_last[0]) m_count++;
               void'(q_addr.pop_front());
               void'(q_data.pop_front());
               void'(q_last.pop_front());
            end
         end else if (CLEAR) begin
            m_count = 0;
         end else if (IN_VALID && m_count != DEPTH) begin
            hs_flag = 1'b1;
            if (CHK && OPCODE > MAXOP) begin
               m_err = 1'b1;
            end else begin
               m_word = pack(FORMAT, OPCODE, WRITEREG, READREG1, READREG2, IMMEDIATE, OFFSET);
               for (int k = 0; k < 4; k++) begin
                  q_addr.push_back(4*m_count + k);
                  q_data.push_back(int'((m_word >> (8*k)) & 32'hFF));
                  q_last.push_back(k == 3);
               end
            end
         end
      end
   end

   bit         chk_en = 1'b0;
   logic [7:0] mem_img [0:DEPTH*4-1];
   int         wr_cycles   = 0;
   int         err_pulses  = 0;

   always @(negedge CLK) begin
      if (chk_en) begin
         m_busy = (q_addr.size() > 0);
         check("mem_write", 32'(MEM_WRITE), 32'(m_busy));
         check("mem_address", 32'(MEM_ADDRESS), m_busy ? q_addr[0] : 0);
         check("mem_writedata", 32'(MEM_WRITEDATA), m_busy ? q_data[0] : 0);
         check("in_ready", 32'(IN_READY), 32'(!m_busy && m_count != DEPTH && !CLEAR));
         check("count", 32'(COUNT), m_count);
         check("full", 32'(FULL), 32'(m_count == DEPTH));
         check("err", 32'(ERR), 32'(m_err));
      end
      if (MEM_WRITE && !MEM_BUSYWAIT) mem_img[MEM_ADDRESS] = MEM_WRITEDATA;
      if (MEM_WRITE) wr_cycles++;
      if (ERR) err_pulses++;
   end

   task automatic scramble_fields();
      FORMAT    = 2'($urandom_range(0, 3));
      OPCODE    = 8'($urandom_range(0, 255));
      WRITEREG  = 3'($urandom_range(0, 7));
      READREG1  = 3'($urandom_range(0, 7));
      READREG2  = 3'($urandom_range(0, 7));
      IMMEDIATE = 8'($urandom_range(0, 255));
      OFFSET    = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_hs(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge CLK); #1;
         got = hs_flag;
      end
      check({name, "_handshake"}, 32'(got), 32'd1);
      IN_VALID = 1'b0;
      scramble_fields();
   endtask

   task automatic send(input int unsigned fmt, op, wr, r1, r2, imm, off, input string name);
      FORMAT = 2'(fmt); OPCODE = 8'(op); WRITEREG = 3'(wr); READREG1 = 3'(r1);
      READREG2 = 3'(r2); IMMEDIATE = 8'(imm); OFFSET = 8'(off);
      IN_VALID = 1'b1;
      wait_hs(name);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200 && q_addr.size() > 0; i++) begin
         @(posedge CLK); #1;
      end
      check({name, "_drained"}, 32'(q_addr.size()), 32'd0);
   endtask

   initial begin
      bit any_hs;
      RESET = 1'b1; CLEAR = 1'b0; IN_VALID = 1'b0; MEM_BUSYWAIT = 1'b0;
      scramble_fields();
      repeat (2) @(posedge CLK);
      #1;
      chk_en = 1'b1;
      check("rst_in_ready", 32'(IN_READY), 32'd1);
      check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
      check("rst_count", 32'(COUNT), 32'd0);
      check("rst_full", 32'(FULL), 32'd0);
      RESET = 1'b0;

      check("pack_reg", pack(0, 8'h01, 4, 2, 7, 8'h55, 8'h66), 32'h01040207);
      check("pack_imm", pack(1, 8'h00, 3, 7, 7, 8'hA5, 8'h33), 32'h000300A5);
      check("pack_branch", pack(2, 8'h02, 5, 1, 3, 8'h11, 8'h80), 32'h02800103);
      check("pack_jump", pack(3, 8'h0C, 5, 6, 7, 8'h11, 8'hFE), 32'h0CFE0000);

      wr_cycles = 0;
      send(0, 8'h01, 4, 2, 7, 8'h5A, 8'h3C, "reg");
      wait_idle("reg");
      check("reg_word", {mem_img[3], mem_img[2], mem_img[1], mem_img[0]}, 32'h01040207);
      check("reg_wr_cycles", 32'(wr_cycles), 32'd4);
      check("reg_count", 32'(COUNT), 32'd1);

      send(1, 8'h00, 3, 7, 7, 8'hA5, 8'hC3, "imm");
      wait_idle("imm");
      check("imm_word", {mem_img[7], mem_img[6], mem_img[5], mem_img[4]}, 32'h000300A5);

      wr_cycles = 0;
      send(3, 8'h0C, 5, 6, 1, 8'h11, 8'hFE, "jump");
      @(posedge CLK); #1;
      MEM_BUSYWAIT = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      MEM_BUSYWAIT = 1'b0;
      wait_idle("jump");
      check("jump_word", {mem_img[11], mem_img[10], mem_img[9], mem_img[8]}, 32'h0CFE0000);
      check("jump_wr_cycles", 32'(wr_cycles), 32'd7);

      send(2, 8'h03, 0, 5, 6, 8'h00, 8'h80, "branch");
      wait_idle("branch");
      check("branch_word", {mem_img[15], mem_img[14], mem_img[13], mem_img[12]}, 32'h03800506);
      check("full_count", 32'(COUNT), 32'd4);
      check("full_flag", 32'(FULL), 32'd1);

      FORMAT = 2'd0; OPCODE = 8'h0A; WRITEREG = 3'd1; READREG1 = 3'd1; READREG2 = 3'd1;
      IN_VALID = 1'b1;
      any_hs = 1'b0;
      repeat (8) begin
         @(posedge CLK); #1;
         any_hs |= hs_flag;
      end
      check("full_held_off", 32'(any_hs), 32'd0);
      check("full_in_ready", 32'(IN_READY), 32'd0);
      CLEAR = 1'b1;
      @(posedge CLK); #1;
      CLEAR = 1'b0;
      check("clear_count", 32'(COUNT), 32'd0);
      wait_hs("fifth");
      wait_idle("fifth");
      check("fifth_word", {mem_img[3], mem_img[2], mem_img[1], mem_img[0]}, 32'h0A010101);

      send(0, 8'h0E, 2, 3, 4, 8'h00, 8'h00, "rst_word");
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("wr2_address", 32'(MEM_ADDRESS), 32'd6);
      #2 RESET = 1'b1;
      #1;
      check("async_mem_write", 32'(MEM_WRITE), 32'd0);
      check("async_address", 32'(MEM_ADDRESS), 32'd0);
      check("async_data", 32'(MEM_WRITEDATA), 32'd0);
      check("async_count", 32'(COUNT), 32'd0);
      check("async_in_ready", 32'(IN_READY), 32'd1);
      @(posedge CLK); #1;
      RESET = 1'b0;
      send(1, 8'h05, 6, 0, 0, 8'h42, 8'h00, "after_rst");
      wait_idle("after_rst");
      check("after_rst_word", {mem_img[3], mem_img[2], mem_img[1], mem_img[0]}, 32'h05060042);

`ifdef ENCODER_OPCODE_CHECK_EN
      err_pulses = 0;
      wr_cycles  = 0;
      send(0, 8'h20, 1, 1, 1, 8'h00, 8'h00, "bad_op");
      repeat (3) @(posedge CLK);
      #1;
      check("bad_err_pulses", 32'(err_pulses), 32'd1);
      check("bad_no_write", 32'(wr_cycles), 32'd0);
      check("bad_count", 32'(COUNT), 32'd1);
`endif

      for (int c = 0; c < 3000; c++) begin
         scramble_fields();
         if ($urandom_range(0, 3) != 0) OPCODE = 8'($urandom_range(0, 15));
         IN_VALID     = ($urandom_range(0, 99) < 60);
         MEM_BUSYWAIT = ($urandom_range(0, 99) < 25);
         CLEAR        = ($urandom_range(0, 99) < 4);
         RESET        = ($urandom_range(0, 999) < 5);
         @(posedge CLK); #1;
      end
      RESET = 1'b0; CLEAR = 1'b0; IN_VALID = 1'b0; MEM_BUSYWAIT = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
